// File: rtl/eeg_epoch_loader.sv
// Multi-channel EEG epoch loader: buffers ADC frames in a small FIFO, writes them
// channel-major into intermediate-result memory, then hands the epoch to inference.
module eeg_epoch_loader #(
    parameter int NUM_CHANNELS      = 2,
    parameter int ADC_W             = 16,
    parameter int DATA_W            = 22,
    parameter int ADDR_W            = 16,
    parameter int SAMPLES_PER_EPOCH = 3000,
    parameter int FIFO_DEPTH        = 8,
    parameter int BASE_ADDR         = 0,
    parameter bit CONTINUOUS        = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_eeg_load,
    input  logic                          new_eeg_data,
    input  logic [NUM_CHANNELS*ADC_W-1:0] eeg,
    input  logic                          mem_ready,
    output logic                          mem_wr_en,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_data,
    output logic                          start_inference,
    input  logic                          inference_done,
    output logic                          inference_complete,
    output logic                          busy,
    output logic                          overflow,
    output logic [7:0]                    dropped_cnt
);

    localparam int FRAME_W = NUM_CHANNELS * ADC_W;
    localparam int CH_W    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(SAMPLES_PER_EPOCH + 1);

    localparam logic [CNT_W-1:0] SPE_C    = CNT_W'(SAMPLES_PER_EPOCH);
    localparam logic [CNT_W-1:0] SPE_M1_C = CNT_W'(SAMPLES_PER_EPOCH - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CHANNELS - 1);
    localparam logic [PTR_W:0]   FIFO_FULL_C = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        INFER = 2'd3
    } state_t;

    state_t state, state_next;

    logic [FRAME_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     fifo_cnt;
    logic [CH_W-1:0]    ch;
    logic [CNT_W-1:0]   accepted_cnt, frame_idx;

    logic               fifo_empty, fifo_full;
    logic               word_fire, pop, push, drop;
    logic               epoch_filled, restart, clear_epoch;
    logic [ADC_W-1:0]   head_sample;
    logic [31:0]        addr_calc;

    // Memory write port: mem_ready is the sink's ready; a word transfers on every
    // cycle mem_wr_en is high. A word is only offered when the previous cycle saw
    // mem_ready high with the FIFO non-empty, so address/data never change under a stall.
    assign fifo_empty   = (fifo_cnt == '0);
    assign fifo_full    = (fifo_cnt == FIFO_FULL_C);
    assign word_fire    = ((state == LOAD) || (state == DRAIN)) && !fifo_empty && mem_ready;
    assign pop          = word_fire && (ch == CH_LAST);
    assign push         = (state == LOAD) && new_eeg_data && (accepted_cnt < SPE_C)
                          && (!fifo_full || pop);
    assign drop         = new_eeg_data && (state != IDLE) && !push;
    assign epoch_filled = push && (accepted_cnt == SPE_M1_C);
    assign restart      = (state == INFER) && inference_done;
    assign clear_epoch  = ((state == IDLE) && start_eeg_load) || restart;
    assign busy         = (state != IDLE);

    assign head_sample  = fifo_mem[rd_ptr][ch*ADC_W +: ADC_W];
    assign addr_calc    = 32'(BASE_ADDR) + 32'(ch) * 32'(SAMPLES_PER_EPOCH) + 32'(frame_idx);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start_eeg_load) state_next = LOAD;
            LOAD:  if (epoch_filled) state_next = DRAIN;
            DRAIN: if (fifo_empty && (frame_idx == SPE_C)) state_next = INFER;
            INFER: if (inference_done) state_next = CONTINUOUS ? LOAD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Frame storage carries no reset; occupancy is tracked by fifo_cnt alone.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= eeg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
            ch           <= '0;
            accepted_cnt <= '0;
            frame_idx    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase

            if (clear_epoch) begin
                ch           <= '0;
                accepted_cnt <= '0;
                frame_idx    <= '0;
            end else begin
                if (push) accepted_cnt <= accepted_cnt + 1'b1;
                if (pop) begin
                    ch        <= '0;
                    frame_idx <= frame_idx + 1'b1;
                end else if (word_fire) begin
                    ch <= ch + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wr_en          <= 1'b0;
            mem_addr           <= '0;
            mem_data           <= '0;
            start_inference    <= 1'b0;
            inference_complete <= 1'b0;
            overflow           <= 1'b0;
            dropped_cnt        <= '0;
        end else begin
            mem_wr_en <= word_fire;
            if (word_fire) begin
                mem_addr <= addr_calc[ADDR_W-1:0];
                mem_data <= DATA_W'(head_sample);
            end
            start_inference    <= (state == DRAIN) && (state_next == INFER);
            inference_complete <= restart;
            if (drop) begin
                overflow <= 1'b1;
                if (dropped_cnt != 8'hFF) dropped_cnt <= dropped_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_eeg_epoch_loader.sv
// Bench for eeg_epoch_loader: small epoch (4 frames, 2 channels, FIFO of 2) against
// a frame-level model of the expected channel-major write stream.
module tb_eeg_epoch_loader;

    localparam int NC     = 2;
    localparam int ADC_W  = 16;
    localparam int DATA_W = 22;
    localparam int ADDR_W = 16;
    localparam int SPE    = 4;
    localparam int DEPTH  = 2;
    localparam int BASE   = 16;
    localparam int W      = ADDR_W + DATA_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_eeg_load = 1'b0;
    logic new_eeg_data = 1'b0;
    logic [NC*ADC_W-1:0] eeg = '0;
    logic mem_ready = 1'b1;
    logic inference_done = 1'b0;

    logic mem_wr_en, start_inference, inference_complete, busy, overflow;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [7:0] dropped_cnt;

    logic c_mem_wr_en, c_start_inference, c_inference_complete, c_busy, c_overflow;
    logic [ADDR_W-1:0] c_mem_addr;
    logic [DATA_W-1:0] c_mem_data;
    logic [7:0] c_dropped_cnt;

    int n_checks = 0;
    int n_fail = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    logic [W-1:0] obs_c_q[$];
    int si_cnt, ic_cnt, si_c_cnt, ic_c_cnt;

    eeg_epoch_loader #(
        .NUM_CHANNELS(NC), .ADC_W(ADC_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .SAMPLES_PER_EPOCH(SPE), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE), .CONTINUOUS(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .start_eeg_load(start_eeg_load), .new_eeg_data(new_eeg_data),
        .eeg(eeg), .mem_ready(mem_ready), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_data(mem_data), .start_inference(start_inference), .inference_done(inference_done),
        .inference_complete(inference_complete), .busy(busy), .overflow(overflow),
        .dropped_cnt(dropped_cnt)
    );

    eeg_epoch_loader #(
        .NUM_CHANNELS(NC), .ADC_W(ADC_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .SAMPLES_PER_EPOCH(SPE), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE), .CONTINUOUS(1'b1)
    ) dut_c (
        .clk(clk), .rst(rst), .start_eeg_load(start_eeg_load), .new_eeg_data(new_eeg_data),
        .eeg(eeg), .mem_ready(mem_ready), .mem_wr_en(c_mem_wr_en), .mem_addr(c_mem_addr),
        .mem_data(c_mem_data), .start_inference(c_start_inference),
        .inference_done(inference_done), .inference_complete(c_inference_complete),
        .busy(c_busy), .overflow(c_overflow), .dropped_cnt(c_dropped_cnt)
    );

    // clock / monitors
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_wr_en)            obs_q.push_back({mem_addr, mem_data});
        if (c_mem_wr_en)          obs_c_q.push_back({c_mem_addr, c_mem_data});
        if (start_inference)      si_cnt++;
        if (inference_complete)   ic_cnt++;
        if (c_start_inference)    si_c_cnt++;
        if (c_inference_complete) ic_c_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_sb();
        exp_q.delete();
        obs_q.delete();
        obs_c_q.delete();
        si_cnt = 0; ic_cnt = 0; si_c_cnt = 0; ic_c_cnt = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        start_eeg_load = 1'b0;
        new_eeg_data = 1'b0;
        inference_done = 1'b0;
        cyc(1);
        rst = 1'b0;
        clear_sb();
    endtask

    task automatic start_load();
        start_eeg_load = 1'b1;
        cyc(1);
        start_eeg_load = 1'b0;
    endtask

    task automatic send_frame(input logic [NC*ADC_W-1:0] f);
        new_eeg_data = 1'b1;
        eeg = f;
        cyc(1);
        new_eeg_data = 1'b0;
    endtask

    task automatic pulse_done();
        inference_done = 1'b1;
        cyc(1);
        inference_done = 1'b0;
    endtask

    // reference model: frame f, channel c lands at BASE + c*SPE + f, zero-extended
    function automatic void expect_frame(input int f, input logic [NC*ADC_W-1:0] frame);
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        for (int c = 0; c < NC; c++) begin
            a = ADDR_W'(BASE + c * SPE + f);
            d = DATA_W'(frame[c*ADC_W +: ADC_W]);
            exp_q.push_back({a, d});
        end
    endfunction

    // tests
    task automatic test_reset();
        apply_reset();
        n_checks++; if (mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got %b need 0", mem_wr_en); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b need 0", busy); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b need 0", overflow); end
        n_checks++; if (dropped_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_dropped got %0d need 0", dropped_cnt); end
        n_checks++; if (start_inference !== 1'b0) begin n_fail++; $display("FAIL reset_start_inf got %b need 0", start_inference); end
        n_checks++; if (inference_complete !== 1'b0) begin n_fail++; $display("FAIL reset_inf_cmpl got %b need 0", inference_complete); end
        n_checks++; if (mem_addr !== '0 || mem_data !== '0) begin n_fail++; $display("FAIL reset_bus got %h/%h need 0/0", mem_addr, mem_data); end
    endtask

    task automatic test_basic_epoch();
        logic [NC*ADC_W-1:0] f;
        apply_reset();
        mem_ready = 1'b1;
        start_load();
        for (int k = 1; k <= SPE; k++) begin
            f = {16'(k * 256 + 2), 16'(k)};
            expect_frame(k - 1, f);
            send_frame(f);
            cyc(4);
        end
        for (int i = 0; i < 50 && si_cnt == 0; i++) cyc(1);
        cyc(2);
        n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL basic_count got %0d need %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_word%0d got addr %0d data %h need addr %0d data %h", i, obs_q[i][W-1:DATA_W], obs_q[i][DATA_W-1:0], exp_q[i][W-1:DATA_W], exp_q[i][DATA_W-1:0]); end
        end
        n_checks++; if (si_cnt !== 1) begin n_fail++; $display("FAIL basic_start_inf pulses got %0d need 1", si_cnt); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_infer got %b need 1", busy); end
        pulse_done();
        cyc(1);
        n_checks++; if (ic_cnt !== 1) begin n_fail++; $display("FAIL basic_inf_cmpl pulses got %0d need 1", ic_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_idle got %b need 0", busy); end
        n_checks++; if (dropped_cnt !== 8'd0) begin n_fail++; $display("FAIL basic_dropped got %0d need 0", dropped_cnt); end
    endtask

    task automatic test_stall_overflow();
        logic [NC*ADC_W-1:0] f [3];
        apply_reset();
        start_load();
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            f[k] = $urandom();
            send_frame(f[k]);
        end
        expect_frame(0, f[0]);
        expect_frame(1, f[1]);
        cyc(2);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL stall_overflow got %b need 1", overflow); end
        n_checks++; if (dropped_cnt !== 8'd1) begin n_fail++; $display("FAIL stall_dropped got %0d need 1", dropped_cnt); end
        n_checks++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL stall_no_write got %0d writes need 0", obs_q.size()); end
        mem_ready = 1'b1;
        cyc(8);
        n_checks++; if (obs_q.size() !== 4) begin n_fail++; $display("FAIL stall_count got %0d need 4", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_word%0d got %h need %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_push_on_pop();
        logic [NC*ADC_W-1:0] fa, fb, fc;
        apply_reset();
        start_load();
        fa = $urandom(); fb = $urandom(); fc = $urandom();
        expect_frame(0, fa); expect_frame(1, fb); expect_frame(2, fc);
        mem_ready = 1'b0;
        send_frame(fa);
        send_frame(fb);
        mem_ready = 1'b1;
        cyc(1);
        send_frame(fc);
        n_checks++; if (dropped_cnt !== 8'd0) begin n_fail++; $display("FAIL pushpop_dropped got %0d need 0", dropped_cnt); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL pushpop_overflow got %b need 0", overflow); end
        cyc(8);
        n_checks++; if (obs_q.size() !== 6) begin n_fail++; $display("FAIL pushpop_count got %0d need 6", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL pushpop_word%0d got %h need %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_epoch();
        logic [NC*ADC_W-1:0] fx;
        apply_reset();
        start_load();
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) send_frame($urandom());
        n_checks++; if (dropped_cnt !== 8'd1) begin n_fail++; $display("FAIL midrst_pre_dropped got %0d need 1", dropped_cnt); end
        mem_ready = 1'b1;
        cyc(1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b need 0", busy); end
        n_checks++; if (mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL midrst_wr_en got %b need 0", mem_wr_en); end
        n_checks++; if (dropped_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_dropped got %0d need 0", dropped_cnt); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL midrst_overflow got %b need 0", overflow); end
        clear_sb();
        cyc(4);
        n_checks++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL midrst_no_write got %0d writes need 0", obs_q.size()); end
        start_load();
        fx = $urandom();
        expect_frame(0, fx);
        send_frame(fx);
        cyc(4);
        n_checks++; if (obs_q.size() !== NC) begin n_fail++; $display("FAIL midrst_restart_count got %0d need %0d", obs_q.size(), NC); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst_word%0d got %h need %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_continuous();
        logic [NC*ADC_W-1:0] f;
        apply_reset();
        start_load();
        for (int k = 0; k < SPE; k++) begin
            send_frame($urandom());
            cyc(3);
        end
        for (int i = 0; i < 50 && si_c_cnt == 0; i++) cyc(1);
        n_checks++; if (si_c_cnt !== 1) begin n_fail++; $display("FAIL cont_start_inf got %0d need 1", si_c_cnt); end
        pulse_done();
        cyc(2);
        n_checks++; if (ic_c_cnt !== 1) begin n_fail++; $display("FAIL cont_inf_cmpl got %0d need 1", ic_c_cnt); end
        n_checks++; if (c_busy !== 1'b1) begin n_fail++; $display("FAIL cont_busy got %b need 1", c_busy); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL noncont_busy got %b need 0", busy); end
        obs_c_q.delete();
        exp_q.delete();
        f = $urandom();
        expect_frame(0, f);
        send_frame(f);
        cyc(4);
        n_checks++; if (obs_c_q.size() !== NC) begin n_fail++; $display("FAIL cont_next_count got %0d need %0d", obs_c_q.size(), NC); end
        for (int i = 0; i < exp_q.size() && i < obs_c_q.size(); i++) begin
            n_checks++;
            if (obs_c_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL cont_next_word%0d got %h need %h", i, obs_c_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_ignored_events();
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            send_frame($urandom());
            cyc(1);
        end
        n_checks++; if (dropped_cnt !== 8'd0) begin n_fail++; $display("FAIL idle_dropped got %0d need 0", dropped_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b need 0", busy); end
        n_checks++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL idle_no_write got %0d need 0", obs_q.size()); end
        start_load();
        pulse_done();
        cyc(3);
        n_checks++; if (ic_cnt !== 0) begin n_fail++; $display("FAIL load_done_ignored got %0d pulses need 0", ic_cnt); end
        n_checks++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL load_no_write got %0d need 0", obs_q.size()); end
        n_checks++; if (dropped_cnt !== 8'd0) begin n_fail++; $display("FAIL load_dropped got %0d need 0", dropped_cnt); end
    endtask

    task automatic test_random_epochs();
        logic [NC*ADC_W-1:0] f;
        int exp_drop;
        apply_reset();
        exp_drop = 0;
        for (int e = 0; e < 3; e++) begin
            exp_q.delete();
            obs_q.delete();
            si_cnt = 0; ic_cnt = 0;
            mem_ready = 1'b1;
            start_load();
            for (int k = 0; k < SPE; k++) begin
                f = $urandom();
                expect_frame(k, f);
                send_frame(f);
                repeat ($urandom_range(1, 6)) begin
                    mem_ready = 1'($urandom_range(0, 1));
                    cyc(1);
                end
                mem_ready = 1'b1;
                cyc(3);
            end
            for (int i = 0; i < 50 && si_cnt == 0; i++) cyc(1);
            n_checks++; if (si_cnt !== 1) begin n_fail++; $display("FAIL rand%0d_start_inf got %0d need 1", e, si_cnt); end
            n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand%0d_count got %0d need %0d", e, obs_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_word%0d got %h need %h", e, i, obs_q[i], exp_q[i]); end
            end
            send_frame($urandom());
            exp_drop++;
            n_checks++; if (dropped_cnt !== 8'(exp_drop)) begin n_fail++; $display("FAIL rand%0d_infer_drop got %0d need %0d", e, dropped_cnt, exp_drop); end
            n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL rand%0d_overflow got %b need 1", e, overflow); end
            pulse_done();
            cyc(1);
            n_checks++; if (ic_cnt !== 1) begin n_fail++; $display("FAIL rand%0d_inf_cmpl got %0d need 1", e, ic_cnt); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rand%0d_idle got %b need 0", e, busy); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_epoch();
        test_stall_overflow();
        test_push_on_pop();
        test_reset_mid_epoch();
        test_continuous();
        test_ignored_events();
        test_random_epochs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eeg_epoch_loader.md
Name: eeg_epoch_loader

Overview:
- Parametrised successor of the single-channel SoC EEG ingest path in front of cim_centralized.
- Accepts multi-channel ADC frames from the SoC controller and buffers them in a small FIFO.
- Drains the FIFO into intermediate-result memory in channel-major layout.
- Once a full sleep epoch is stored, hands off to the inference engine and reports completion back to the SoC.

Parameters:
- NUM_CHANNELS, 2, EEG channels per frame.
- ADC_W, 16, width of one ADC sample (unsigned).
- DATA_W, 22, memory write-data width; samples are zero-extended to it.
- ADDR_W, 16, intermediate-result memory address width.
- SAMPLES_PER_EPOCH, 3000, frames per sleep epoch.
- FIFO_DEPTH, 8, frames buffered; power of two, at least 2.
- BASE_ADDR, 0, memory address of channel 0, sample 0.
- CONTINUOUS, 0, 1 = return to LOAD after inference instead of IDLE.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start_eeg_load  in  1  pulse; begin loading an epoch.
- new_eeg_data  in  1  pulse; eeg carries one valid frame.
- eeg  in  NUM_CHANNELS*ADC_W  frame; channel c occupies bits [c*ADC_W +: ADC_W].
- mem_ready  in  1  memory accepts a write this cycle.
- mem_wr_en  out  1  memory write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_data  out  DATA_W  write data.
- start_inference  out  1  one-cycle pulse to the inference engine.
- inference_done  in  1  pulse from the inference engine.
- inference_complete  out  1  one-cycle pulse to the SoC.
- busy  out  1  high whenever state is not IDLE.
- overflow  out  1  sticky; a frame was dropped.
- dropped_cnt  out  8  count of dropped frames; saturates at 255.

Behaviour:
- Reset (rst sampled high at a clk edge):
  - state goes to IDLE; FIFO is emptied; all counters are cleared.
  - All outputs go to 0, including overflow and dropped_cnt.
  - Reset takes priority over every other input. A reset mid-epoch abandons that epoch; no further memory writes occur.
- State IDLE:
  - start_eeg_load -> LOAD; frame_idx cleared to 0.
  - new_eeg_data is ignored and not counted as a drop.
- State LOAD, push side:
  - On new_eeg_data, push the frame if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the frame is dropped: overflow is set and dropped_cnt is incremented.
  - Each accepted frame increments accepted_cnt.
  - When accepted_cnt reaches SAMPLES_PER_EPOCH, state -> DRAIN; further new_eeg_data is dropped and counted.
- Drain engine (active in LOAD and DRAIN):
  - Holds the head frame and a channel index ch.
  - Each cycle the FIFO is non-empty and mem_ready=1:
    - mem_wr_en=1 (registered output);
    - mem_addr = BASE_ADDR + ch*SAMPLES_PER_EPOCH + frame_idx, truncated to ADDR_W;
    - mem_data = zero-extended channel ch;
    - ch increments.
  - When ch = NUM_CHANNELS-1 is written, the frame pops, ch returns to 0 and frame_idx increments.
  - mem_ready=0 stalls with no write; address and data are held.
  - Throughput: one word per cycle. Latency: a frame pushed into an empty FIFO at edge t has its ch0 write on the bus after edge t+1.
- State DRAIN:
  - When the FIFO is empty and frame_idx = SAMPLES_PER_EPOCH -> INFER.
  - start_inference pulses for exactly one cycle on entry to INFER.
- State INFER:
  - On inference_done -> inference_complete pulses for one cycle.
  - Next state is IDLE, or LOAD when CONTINUOUS=1; in LOAD, counters are cleared.
  - start_eeg_load is ignored in INFER, DRAIN and LOAD.
  - new_eeg_data in INFER is dropped and counted.
- Simultaneous events:
  - A push and a pop in the same cycle with the FIFO full keeps it full and does not drop.
  - inference_done outside INFER is ignored.
- Only rst clears overflow and dropped_cnt.

Test Plan:
- NUM_CHANNELS=2, SAMPLES_PER_EPOCH=4, FIFO_DEPTH=2, BASE_ADDR=16, mem_ready=1; send 4 frames {ch1,ch0}={0x0102,0x0001}, {0x0202,0x0002}, ... 5 cycles apart:
  - required write order is addr 16,20,17,21,18,22,19,23 with data 1,0x102,2,0x202,3,0x302,4,0x402;
  - then one start_inference pulse.
- Same configuration with mem_ready=0 held while 3 frames arrive back to back:
  - first 2 frames buffered, third dropped;
  - overflow=1, dropped_cnt=1;
  - after mem_ready=1, exactly 4 writes (frames 0,1).
- Drain stalls with FIFO full; push on the exact cycle the final word of the head frame pops -> frame accepted, dropped_cnt unchanged.
- rst asserted after 2 frames of an epoch:
  - next cycle busy=0, mem_wr_en=0, dropped_cnt=0;
  - following start_eeg_load restarts writes at addr 16.
- CONTINUOUS=1: inference_done in INFER gives one inference_complete pulse; busy stays 1; next epoch frame 0 writes addr 16 without a start_eeg_load.
- new_eeg_data in IDLE, and inference_done in LOAD -> no writes, no drop count, no inference_complete.
